// File: rtl/seg7_scan_display.sv
// seg7_scan_display: time-multiplexed hex driver for an N-digit common-anode 7-segment display
// Define SEG7_LZB_EN to enable leading-zero blanking of the displayed value.
module seg7_scan_display #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic                    load_pending,
    output logic                    frame_start,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg
);
    localparam int DW = $clog2(REFRESH_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || REFRESH_DIV < 2 ||
        BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV) begin : g_param_err
        $error("seg7_scan_display: illegal parameter set");
    end

    logic [DW-1:0]           div_cnt;
    logic [IW-1:0]           digit_idx;
    logic [4*NUM_DIGITS-1:0] stg_data, sh_data;
    logic [NUM_DIGITS-1:0]   stg_dp, sh_dp, stg_en, sh_en;
    logic [NUM_DIGITS-1:0]   sel, lzb, an_d;
    logic [3:0]              nib;
    logic [7:0]              seg_d;
    logic                    slot_end, boundary, show;

    assign slot_end = div_cnt == DW'(REFRESH_DIV - 1);
    assign boundary = slot_end && digit_idx == IW'(NUM_DIGITS - 1);

    always_comb begin
        sel = '0;
        nib = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (digit_idx == IW'(i)) begin
                sel[i] = 1'b1;
                nib    = sh_data[4*i +: 4];
            end
    end

`ifdef SEG7_LZB_EN
    logic zero;
    // A digit blanks only while it and every more significant nibble are zero.
    always_comb begin
        lzb  = '0;
        zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero   = zero & (sh_data[4*i +: 4] == 4'h0);
            lzb[i] = zero & ~sh_dp[i];
        end
    end
`else
    assign lzb = '0;
`endif

    assign show  = div_cnt >= DW'(BLANK_CYCLES) && |(sh_en & sel) && !(|(lzb & sel));
    assign an_d  = show ? ~sel : '1;
    assign seg_d = show ? {~|(sh_dp & sel), HEX[nib]} : 8'hFF;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt      <= '0;
            digit_idx    <= '0;
            stg_data     <= '0;
            stg_dp       <= '0;
            stg_en       <= '0;
            sh_data      <= '0;
            sh_dp        <= '0;
            sh_en        <= '0;
            load_pending <= 1'b0;
            frame_start  <= 1'b0;
            an           <= '1;
            seg          <= 8'hFF;
        end else begin
            div_cnt     <= slot_end ? '0 : div_cnt + 1'b1;
            frame_start <= boundary;
            if (slot_end)
                digit_idx <= digit_idx == IW'(NUM_DIGITS - 1) ? '0 : digit_idx + 1'b1;
            // Shadow takes the pre-edge staging, so a load on the boundary waits a frame.
            if (boundary) begin
                sh_data <= stg_data;
                sh_dp   <= stg_dp;
                sh_en   <= stg_en;
            end
            if (load) begin
                stg_data <= data_in;
                stg_dp   <= dp_in;
                stg_en   <= digit_en;
            end
            load_pending <= load | (load_pending & ~boundary);
            an           <= an_d;
            seg          <= seg_d;
        end
    end
endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: scoreboard bench; expected frames are queued, a monitor checks each slot.
module tb_seg7_scan_display;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = '0;
    logic        load = 1'b0;
    logic        load_pending, frame_start;
    logic [3:0]  an;
    logic [7:0]  seg;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [47:0] exp_q [$];

    seg7_scan_display #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in), .digit_en(digit_en),
        .load(load), .load_pending(load_pending), .frame_start(frame_start), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_start && n < 100);
        if (!frame_start) check("frame_start timeout", 32'(n), 32'd0);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
        data_in  = d;
        dp_in    = dp;
        digit_en = en;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    task automatic push_frame(input logic [11:0] s0, input logic [11:0] s1,
                              input logic [11:0] s2, input logic [11:0] s3);
        exp_q.push_back({s3, s2, s1, s0});
    endtask

    initial begin
        int          t = 99;
        int          fr = 0;
        bit          act = 1'b0;
        logic [47:0] cur = '0;
        forever begin
            @(negedge clk);
            if (frame_start) begin
                t   = 0;
                fr++;
                act = exp_q.size() > 0;
                if (act) cur = exp_q.pop_front();
            end else if (t < 99) begin
                t++;
            end
            if (act)
                for (int s = 0; s < 4; s++) begin
                    if (t == 8*s + 2) check($sformatf("frame%0d slot%0d blank", fr, s), 32'({an, seg}), 32'hFFF);
                    if (t == 8*s + 5) check($sformatf("frame%0d slot%0d lit", fr, s), 32'({an, seg}), 32'(cur[12*s +: 12]));
                end
        end
    end

    initial begin
        int n;
        tick(3);
        check("reset an/seg", 32'({an, seg}), 32'hFFF);
        check("reset pending", 32'(load_pending), 32'd0);
        check("reset frame_start", 32'(frame_start), 32'd0);
        rst_n = 1'b1;
        do_load(16'h12AF, 4'h0, 4'hF);
        check("pending after load", 32'(load_pending), 32'd1);
        wait_frame(n);
        check("first frame latency", 32'(n), 32'd31);
        check("pending cleared f1", 32'(load_pending), 32'd0);
        push_frame(12'hE8E, 12'hD88, 12'hBA4, 12'h7F9);
        tick(10);
        do_load(16'h1234, 4'h0, 4'hF);
        tick();
        do_load(16'h5678, 4'h0, 4'hF);
        check("pending mid-frame", 32'(load_pending), 32'd1);
        wait_frame(n);
        check("pending cleared f2", 32'(load_pending), 32'd0);
        push_frame(12'hE80, 12'hDD8, 12'hB82, 12'h792);
        tick(31);
        check("pre-boundary pending", 32'(load_pending), 32'd0);
        check("pre-boundary frame_start", 32'(frame_start), 32'd0);
        do_load(16'hFFFF, 4'h0, 4'hF);
        check("boundary-load frame_start", 32'(frame_start), 32'd1);
        check("boundary-load pending", 32'(load_pending), 32'd1);
        push_frame(12'hE80, 12'hDD8, 12'hB82, 12'h792);
        tick(16);
        check("pending held f3", 32'(load_pending), 32'd1);
        wait_frame(n);
        check("frame period", 32'(n), 32'd16);
        check("pending cleared f4", 32'(load_pending), 32'd0);
        push_frame(12'hE8E, 12'hD8E, 12'hB8E, 12'h78E);
        tick(5);
        do_load(16'h0000, 4'b0001, 4'b0101);
        wait_frame(n);
`ifdef SEG7_LZB_EN
        push_frame(12'hE40, 12'hFFF, 12'hFFF, 12'hFFF);
        do_load(16'h0040, 4'h0, 4'hF);
        wait_frame(n);
        push_frame(12'hEC0, 12'hD99, 12'hFFF, 12'hFFF);
        do_load(16'h0000, 4'h0, 4'hF);
        wait_frame(n);
        push_frame(12'hEC0, 12'hFFF, 12'hFFF, 12'hFFF);
`else
        push_frame(12'hE40, 12'hFFF, 12'hBC0, 12'hFFF);
`endif
        wait_frame(n);
        tick(20);
        do_load(16'h4321, 4'h0, 4'hF);
        check("pending before reset", 32'(load_pending), 32'd1);
        rst_n = 1'b0;
        tick();
        check("mid reset an/seg", 32'({an, seg}), 32'hFFF);
        check("mid reset pending", 32'(load_pending), 32'd0);
        check("mid reset frame_start", 32'(frame_start), 32'd0);
        rst_n = 1'b1;
        wait_frame(n);
        check("restart latency", 32'(n), 32'd32);
        check("restart pending", 32'(load_pending), 32'd0);
        push_frame(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
        tick(34);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
